// File: rtl/riscv_pkg.sv
// Shared types for the 3-stage core: register index width, operand forward
// selects and the hazard controller state encoding.
package riscv_pkg;

    localparam int REGW = 5;

    typedef logic [REGW-1:0] reg_idx_t;
    typedef logic [1:0]      fwd_sel_t;

    localparam fwd_sel_t FWD_RF = 2'b00;
    localparam fwd_sel_t FWD_M  = 2'b01;
    localparam fwd_sel_t FWD_W  = 2'b10;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } ctrl_state_e;

    // A load result is not ready in M, so only non-load producers forward from M.
    function automatic fwd_sel_t fwdSelect(input reg_idx_t rs,
                                           input reg_idx_t rdM,
                                           input logic     wenM,
                                           input logic     loadM,
                                           input reg_idx_t rdW,
                                           input logic     wenW);
        fwd_sel_t sel;
        sel = FWD_RF;
        if (rs != '0 && rs == rdM && wenM && !loadM) begin
            sel = FWD_M;
        end else if (rs != '0 && rs == rdW && wenW) begin
            sel = FWD_W;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Pipeline-side view of the hazard controller: stage operand/destination info
// in, stall/flush/forward controls out.
interface pipeline_ctrl_if;
    import riscv_pkg::*;

    reg_idx_t rs1_e;
    reg_idx_t rs2_e;
    reg_idx_t rd_m;
    logic     reg_write_m;
    logic     is_load_m;
    logic     dmem_req_m;
    logic     dmem_ack_i;
    logic     br_taken_e;

    fwd_sel_t fwd_a_o;
    fwd_sel_t fwd_b_o;
    logic     stall_fd_o;
    logic     stall_e_o;
    logic     bubble_m_o;
    logic     stall_m_o;
    logic     flush_fd_o;

    modport master (
        output rs1_e, rs2_e, rd_m, reg_write_m, is_load_m,
               dmem_req_m, dmem_ack_i, br_taken_e,
        input  fwd_a_o, fwd_b_o, stall_fd_o, stall_e_o,
               bubble_m_o, stall_m_o, flush_fd_o
    );

    modport slave (
        input  rs1_e, rs2_e, rd_m, reg_write_m, is_load_m,
               dmem_req_m, dmem_ack_i, br_taken_e,
        output fwd_a_o, fwd_b_o, stall_fd_o, stall_e_o,
               bubble_m_o, stall_m_o, flush_fd_o
    );

endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && cnt_q != '1) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and stall controller for the F/D, E, M/WB core: forwarding selects,
// load-use interlock, data-memory wait stall, branch flush, perf counters.
module pipeline_ctrl
    import riscv_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNTW        = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    pipeline_ctrl_if.slave   ctrl,
    output logic [CNTW-1:0]  stall_cnt_o,
    output logic [CNTW-1:0]  flush_cnt_o,
    output logic             err_o
);

    localparam int WAITW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAITW-1:0] TIMEOUT_V = WAITW'(MEM_TIMEOUT);

    ctrl_state_e      state_q, state_d;
    reg_idx_t         rd_w_q;
    logic             wen_w_q;
    logic [WAITW-1:0] wait_q, wait_d;
    logic             err_q;
    logic             errSet;

    logic memBusy;
    logic hazard;
    logic stallFd, stallE, stallM, bubbleM, flushFd;

    assign memBusy = ctrl.dmem_req_m && !ctrl.dmem_ack_i;
    assign hazard  = ctrl.reg_write_m && ctrl.is_load_m &&
                     ((ctrl.rs1_e != '0 && ctrl.rs1_e == ctrl.rd_m) ||
                      (ctrl.rs2_e != '0 && ctrl.rs2_e == ctrl.rd_m));

    // Priority: memory wait over load-use over taken branch.
    always_comb begin
        state_d = state_q;
        stallFd = 1'b0;
        stallE  = 1'b0;
        stallM  = 1'b0;
        bubbleM = 1'b0;
        flushFd = 1'b0;
        unique case (state_q)
            RUN: begin
                if (memBusy) begin
                    {stallFd, stallE, stallM} = 3'b111;
                    state_d = MEM_WAIT;
                end else if (hazard) begin
                    {stallFd, stallE, bubbleM} = 3'b111;
                    state_d = LU_STALL;
                end else begin
                    flushFd = ctrl.br_taken_e;
                end
            end
            LU_STALL: begin
                state_d = RUN;
                if (memBusy) begin
                    {stallFd, stallE, stallM} = 3'b111;
                end else begin
                    flushFd = ctrl.br_taken_e;
                end
            end
            MEM_WAIT: begin
                if (!ctrl.dmem_ack_i) begin
                    {stallFd, stallE, stallM} = 3'b111;
                end else begin
                    flushFd = ctrl.br_taken_e;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Wait counter saturates at the timeout; the FSM itself keeps waiting.
    always_comb begin
        wait_d = wait_q;
        errSet = 1'b0;
        if (state_q == RUN && state_d == MEM_WAIT) begin
            wait_d = '0;
        end else if (state_q == MEM_WAIT) begin
            if (wait_q != TIMEOUT_V) begin
                wait_d = wait_q + WAITW'(1);
            end
            errSet = (wait_d == TIMEOUT_V);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RUN;
            rd_w_q  <= '0;
            wen_w_q <= 1'b0;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (!stallM) begin
                rd_w_q  <= ctrl.rd_m;
                wen_w_q <= ctrl.reg_write_m;
            end
            if (errSet) begin
                err_q <= 1'b1;
            end
        end
    end

    assign ctrl.fwd_a_o    = fwdSelect(ctrl.rs1_e, ctrl.rd_m, ctrl.reg_write_m,
                                       ctrl.is_load_m, rd_w_q, wen_w_q);
    assign ctrl.fwd_b_o    = fwdSelect(ctrl.rs2_e, ctrl.rd_m, ctrl.reg_write_m,
                                       ctrl.is_load_m, rd_w_q, wen_w_q);
    assign ctrl.stall_fd_o = stallFd;
    assign ctrl.stall_e_o  = stallE;
    assign ctrl.stall_m_o  = stallM;
    assign ctrl.bubble_m_o = bubbleM;
    assign ctrl.flush_fd_o = flushFd;
    assign err_o           = err_q;

    sat_counter #(.WIDTH(CNTW)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc   (stallE),
        .clr   (1'b0),
        .cnt_o (stall_cnt_o)
    );

    sat_counter #(.WIDTH(CNTW)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc   (flushFd),
        .clr   (1'b0),
        .cnt_o (flush_cnt_o)
    );

endmodule
